// File: rtl/sdram_frame_writer.sv
// sdram_frame_writer
//   Packs 24-bit RGB pixels into DATA_W-bit SDRAM words, buffers them in a
//   show-ahead FIFO and writes them out as Avalon-MM bursts. Frames rotate
//   through a ring of NUM_BUF base addresses; the reader picks last_buf.
//
// Ports
//   clk_100, reset              single clock, synchronous active-high reset
//   arm                         re-arm: ring to slot 0, clear sticky flags
//   start_frame, frame_words    frame start pulse and length in words
//   buf_base                    32-bit slot per buffer, low ADDR_W bits used
//   r_fb/g_fb/b_fb, data_fb_valid  pixel stream
//   avm_*                       Avalon-MM burst write master
//   end_frame                   one-cycle pulse after the last beat of a frame
//   last_buf, cur_buf           completed / in-progress ring index
//   busy, overflow, frame_err   status (overflow and frame_err are sticky)
//   fifo_level                  FIFO occupancy
//
// Build option
//   SDRAM_WR_SWAP_EN            reverse the 32-bit lanes of avm_writedata
module sdram_frame_writer #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 29,
    parameter int BURST_LEN  = 32,
    parameter int FIFO_DEPTH = 256,
    parameter int NUM_BUF    = 3
) (
    input  logic                          clk_100,
    input  logic                          reset,
    input  logic                          arm,
    input  logic                          start_frame,
    input  logic [23:0]                   frame_words,
    input  logic [NUM_BUF*32-1:0]         buf_base,
    input  logic [7:0]                    r_fb,
    input  logic [7:0]                    g_fb,
    input  logic [7:0]                    b_fb,
    input  logic                          data_fb_valid,
    output logic [ADDR_W-1:0]             avm_address,
    output logic [7:0]                    avm_burstcount,
    output logic                          avm_write,
    output logic [DATA_W-1:0]             avm_writedata,
    output logic [DATA_W/8-1:0]           avm_byteenable,
    input  logic                          avm_waitrequest,
    output logic                          end_frame,
    output logic [2:0]                    last_buf,
    output logic [2:0]                    cur_buf,
    output logic                          busy,
    output logic                          overflow,
    output logic                          frame_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PPW = DATA_W / 32;
    localparam int PIW = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int LVW = FAW + 1;
    localparam logic [2:0]     LAST_IDX = 3'(NUM_BUF - 1);
    localparam logic [PIW-1:0] LAST_PIX = PIW'(PPW - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_BURST, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [23:0]         rem_q, rem_d;
    logic [7:0]          bc_q, bc_d;
    logic [7:0]          beat_q, beat_d;
    logic [2:0]          cur_q, cur_d;
    logic [2:0]          last_q, last_d;

    logic                armed_q, arm_pend_q, ovf_q, ferr_q;

    logic                cap_q;
    logic [PIW-1:0]      pix_q;
    logic [23:0]         cnt_q, fw_q;
    logic [PPW-1:0][31:0] pack_q;

    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [FAW-1:0]      wr_q, rd_q;
    logic [LVW-1:0]      lvl_q;

    logic [31:0]         pixel;
    logic [PPW-1:0][31:0] push_word;
    logic                arm_now, start_ok, push_try, full, push_ok, pop;
    logic [ADDR_W-1:0]   base_sel;
    logic [23:0]         lvl_ext, need, bc_sel;
    logic [DATA_W-1:0]   head, wd;
    logic                unused_bits;

    assign unused_bits = ^buf_base;
    assign pixel       = {8'd0, b_fb, g_fb, r_fb};

    // A pending or concurrent arm is applied only in IDLE and beats start_frame.
    assign arm_now  = arm || arm_pend_q;
    assign start_ok = (state_q == S_IDLE) && start_frame && armed_q && !arm_now
                      && (frame_words != 24'd0);

    assign push_try = cap_q && armed_q && data_fb_valid && (pix_q == LAST_PIX);
    assign full     = (lvl_q == LVW'(FIFO_DEPTH));
    assign push_ok  = push_try && !full;
    assign pop      = (state_q == S_BURST) && !avm_waitrequest;

    // The word is pushed on the cycle its last lane arrives, so the incoming
    // pixel is spliced straight into the top lane.
    always_comb begin
        push_word        = pack_q;
        push_word[PPW-1] = pixel;
    end

    always_comb begin
        base_sel = buf_base[ADDR_W-1:0];
        for (int i = 0; i < NUM_BUF; i++)
            if (cur_q == 3'(i)) base_sel = buf_base[32*i +: ADDR_W];
    end

    // Once capture is complete the FIFO may hold fewer words than rem
    // (dropped words), so the burst is also clipped to what is buffered.
    always_comb begin
        lvl_ext = 24'(lvl_q);
        need    = (rem_q < 24'(BURST_LEN)) ? rem_q : 24'(BURST_LEN);
        bc_sel  = need;
        if (!cap_q && lvl_ext < bc_sel) bc_sel = lvl_ext;
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        bc_d      = bc_q;
        beat_d    = beat_q;
        cur_d     = cur_q;
        last_d    = last_q;
        avm_write = 1'b0;
        end_frame = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arm_now) begin
                    cur_d = 3'd0;
                end else if (start_ok) begin
                    addr_d  = base_sel;
                    rem_d   = frame_words;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (!cap_q && lvl_q == '0) begin
                    state_d = S_DONE;
                end else if (lvl_ext >= need || (!cap_q && lvl_q != '0)) begin
                    bc_d    = bc_sel[7:0];
                    beat_d  = 8'd0;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                avm_write = 1'b1;
                if (!avm_waitrequest) begin
                    beat_d = beat_q + 8'd1;
                    if (beat_q == bc_q - 8'd1) begin
                        addr_d  = addr_q + ADDR_W'(bc_q);
                        rem_d   = rem_q - 24'(bc_q);
                        state_d = (rem_q == 24'(bc_q)) ? S_DONE : S_FILL;
                    end
                end
            end
            S_DONE: begin
                end_frame = 1'b1;
                last_d    = cur_q;
                cur_d     = (cur_q == LAST_IDX) ? 3'd0 : cur_q + 3'd1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            bc_q    <= '0;
            beat_q  <= '0;
            cur_q   <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            bc_q    <= bc_d;
            beat_q  <= beat_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge clk_100) begin
        if (reset) begin
            armed_q    <= 1'b0;
            arm_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else if (state_q == S_IDLE && arm_now) begin
            armed_q    <= 1'b1;
            arm_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            if (arm)                                 arm_pend_q <= 1'b1;
            if (start_frame && state_q != S_IDLE)    ferr_q     <= 1'b1;
            if (push_try && full)                    ovf_q      <= 1'b1;
        end
    end

    // Capture counts pushed and dropped words alike; it closes after
    // frame_words words so trailing pixels fall on the floor.
    always_ff @(posedge clk_100) begin
        if (reset) begin
            cap_q  <= 1'b0;
            pix_q  <= '0;
            cnt_q  <= '0;
            fw_q   <= '0;
            pack_q <= '0;
        end else if (start_ok) begin
            cap_q <= 1'b1;
            pix_q <= '0;
            cnt_q <= '0;
            fw_q  <= frame_words;
        end else if (cap_q && armed_q && data_fb_valid) begin
            if (pix_q == LAST_PIX) begin
                pix_q <= '0;
                cnt_q <= cnt_q + 24'd1;
                if (cnt_q + 24'd1 == fw_q) cap_q <= 1'b0;
            end else begin
                pack_q[pix_q] <= pixel;
                pix_q         <= pix_q + PIW'(1);
            end
        end
    end

    always_ff @(posedge clk_100) begin
        if (push_ok) mem[wr_q] <= push_word;
    end

    always_ff @(posedge clk_100) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + FAW'(1);
            if (pop)     rd_q <= rd_q + FAW'(1);
            lvl_q <= lvl_q + LVW'(push_ok) - LVW'(pop);
        end
    end

    assign head = mem[rd_q];

`ifdef SDRAM_WR_SWAP_EN
    always_comb begin
        wd = '0;
        for (int i = 0; i < PPW; i++)
            wd[i*32 +: 32] = head[(PPW-1-i)*32 +: 32];
    end
`else
    assign wd = head;
`endif

    // Bus fields read zero outside a burst so nothing undefined leaks out.
    assign avm_writedata  = avm_write ? wd     : '0;
    assign avm_address    = avm_write ? addr_q : '0;
    assign avm_burstcount = avm_write ? bc_q   : '0;
    assign avm_byteenable = '1;
    assign last_buf       = last_q;
    assign cur_buf        = cur_q;
    assign busy           = (state_q != S_IDLE) || (lvl_q != '0);
    assign overflow       = ovf_q;
    assign frame_err      = ferr_q;
    assign fifo_level     = lvl_q;

endmodule

// File: tb/tb_sdram_frame_writer.sv
module tb_sdram_frame_writer;
    localparam int DW = 64, AW = 29, BL = 32, FD = 256, NB = 3;

    logic             clk_100 = 1'b0;
    logic             reset, arm, start_frame, data_fb_valid, avm_waitrequest;
    logic [23:0]      frame_words;
    logic [NB*32-1:0] buf_base;
    logic [7:0]       r_fb, g_fb, b_fb;
    logic [AW-1:0]    avm_address;
    logic [7:0]       avm_burstcount;
    logic             avm_write, end_frame, busy, overflow, frame_err;
    logic [DW-1:0]    avm_writedata;
    logic [DW/8-1:0]  avm_byteenable;
    logic [2:0]       last_buf, cur_buf;
    logic [8:0]       fifo_level;

    sdram_frame_writer #(.DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL),
                         .FIFO_DEPTH(FD), .NUM_BUF(NB)) dut (
        .clk_100(clk_100), .reset(reset), .arm(arm), .start_frame(start_frame),
        .frame_words(frame_words), .buf_base(buf_base), .r_fb(r_fb), .g_fb(g_fb),
        .b_fb(b_fb), .data_fb_valid(data_fb_valid), .avm_address(avm_address),
        .avm_burstcount(avm_burstcount), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .end_frame(end_frame),
        .last_buf(last_buf), .cur_buf(cur_buf), .busy(busy), .overflow(overflow),
        .frame_err(frame_err), .fifo_level(fifo_level));

    always #5 clk_100 = ~clk_100;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: expected beats as (address, burstcount, data) in order.
    logic [AW-1:0] q_addr[$];
    logic [7:0]    q_bc[$];
    logic [63:0]   q_data[$];
    int            m_cur = 0, m_last = 0;
    bit            ovf_mode = 0;
    int            n_end = 0, beat_idx = 0, max_lvl = 0;
    int            wr_mode = 0, cyc = 0, hold_end = 0;

    // Bus monitor
    bit            prev_stall = 0;
    logic [AW-1:0] p_addr;
    logic [7:0]    p_bc;
    logic [63:0]   p_data;
    logic [8:0]    p_lvl;

    always @(negedge clk_100) begin
        if (reset) begin
            prev_stall = 0;
            beat_idx   = 0;
        end else begin
            if (end_frame) begin
                n_end++;
                if (!ovf_mode) chk("end_after_last", 64'(q_data.size()), 64'd0);
            end
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
            if (prev_stall) begin
                chk("hold_write", 64'(avm_write), 64'd1);
                chk("hold_addr",  64'(avm_address), 64'(p_addr));
                chk("hold_bc",    64'(avm_burstcount), 64'(p_bc));
                chk("hold_data",  avm_writedata, p_data);
                chk("no_pop",     64'(fifo_level >= p_lvl), 64'd1);
            end
            if (avm_write && !avm_waitrequest) begin
                if (!ovf_mode) begin
                    if (q_data.size() == 0) chk("extra_beat", 64'd1, 64'd0);
                    else begin
                        chk("beat_addr", 64'(avm_address), 64'(q_addr.pop_front()));
                        chk("beat_bc",   64'(avm_burstcount), 64'(q_bc.pop_front()));
                        chk("beat_data", avm_writedata, q_data.pop_front());
                    end
                end
                beat_idx++;
                if (beat_idx == int'(avm_burstcount)) beat_idx = 0;
            end
            prev_stall = avm_write && avm_waitrequest;
            p_addr = avm_address;
            p_bc   = avm_burstcount;
            p_data = avm_writedata;
            p_lvl  = fifo_level;
        end
    end

    // Slave stall generator: 0 none, 1 random, 2 five-cycle stall on beat 10,
    // 3 held high until cycle hold_end.
    initial begin
        int stall_cnt;
        stall_cnt = 0;
        avm_waitrequest = 1'b0;
        forever begin
            @(posedge clk_100); #1;
            cyc++;
            case (wr_mode)
                1: avm_waitrequest = ($urandom_range(0, 3) == 0);
                2: begin
                    if (avm_write && beat_idx == 10 && stall_cnt < 5) begin
                        avm_waitrequest = 1'b1;
                        stall_cnt++;
                    end else begin
                        avm_waitrequest = 1'b0;
                        if (beat_idx != 10) stall_cnt = 0;
                    end
                end
                3: avm_waitrequest = (cyc < hold_end);
                default: avm_waitrequest = 1'b0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk_100); #1;
    endtask

    task automatic drive_pix(input logic [31:0] p);
        data_fb_valid = 1'b1;
        {b_fb, g_fb, r_fb} = p[23:0];
    endtask

    task automatic wait_end(input int n0);
        for (int c = 0; c < 6000 && n_end == n0; c++) tick();
        if (n_end == n0) chk("end_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_frame(input int nw, input int extra, input bit gaps, input bit mid);
        logic [31:0]   px[$];
        logic [AW-1:0] base;
        int            n0, bc;
        for (int i = 0; i < 2*nw + extra; i++) px.push_back({8'd0, 24'($urandom)});
        base = buf_base[32*m_cur +: AW];
        for (int k = 0; k*BL < nw; k++) begin
            bc = (nw - k*BL < BL) ? nw - k*BL : BL;
            for (int j = 0; j < bc; j++) begin
                int w;
                w = k*BL + j;
                q_addr.push_back(base + AW'(k*BL));
                q_bc.push_back(8'(bc));
`ifdef SDRAM_WR_SWAP_EN
                q_data.push_back({px[2*w], px[2*w+1]});
`else
                q_data.push_back({px[2*w+1], px[2*w]});
`endif
            end
        end
        // Pixel outside any frame must vanish.
        drive_pix({8'd0, 24'($urandom)});
        tick();
        data_fb_valid = 1'b0;
        start_frame = 1'b1;
        frame_words = 24'(nw);
        n0 = n_end;
        tick();
        start_frame = 1'b0;
        frame_words = 24'($urandom);
        for (int i = 0; i < px.size(); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) tick();
            drive_pix(px[i]);
            if (mid && i == nw)     start_frame = 1'b1;
            if (mid && i == nw + 4) arm = 1'b1;
            tick();
            data_fb_valid = 1'b0;
            start_frame   = 1'b0;
            arm           = 1'b0;
        end
        if (mid) begin
            chk("ferr_set", 64'(frame_err), 64'd1);
            chk("cur_hold", 64'(cur_buf), 64'(m_cur));
        end
        wait_end(n0);
        m_last = m_cur;
        m_cur  = (m_cur + 1) % NB;
        chk("last_buf", 64'(last_buf), 64'(m_last));
        chk("cur_buf",  64'(cur_buf),  64'(m_cur));
        tick();
        if (mid) begin
            m_cur = 0;
            chk("arm_pend_cur",  64'(cur_buf),   64'd0);
            chk("arm_pend_ferr", 64'(frame_err), 64'd0);
        end
        tick();
        chk("end_once",  64'(n_end - n0), 64'd1);
        chk("q_drained", 64'(q_data.size()), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    task automatic run_overflow();
        int n0;
        ovf_mode = 1;
        max_lvl  = 0;
        hold_end = cyc + 600;
        wr_mode  = 3;
        start_frame = 1'b1;
        frame_words = 24'd512;
        n0 = n_end;
        tick();
        start_frame = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            drive_pix({8'd0, 24'($urandom)});
            if (i == 100) start_frame = 1'b1;
            tick();
            start_frame = 1'b0;
        end
        data_fb_valid = 1'b0;
        wait_end(n0);
        m_last = m_cur;
        m_cur  = (m_cur + 1) % NB;
        chk("ovf_flag",  64'(overflow), 64'd1);
        chk("ovf_ferr",  64'(frame_err), 64'd1);
        chk("ovf_max",   64'(max_lvl), 64'(FD));
        chk("ovf_last",  64'(last_buf), 64'(m_last));
        chk("ovf_cur",   64'(cur_buf), 64'(m_cur));
        tick();
        chk("ovf_empty", 64'(fifo_level), 64'd0);
        ovf_mode = 0;
        wr_mode  = 1;
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; start_frame = 1'b0; data_fb_valid = 1'b0;
        frame_words = '0; r_fb = '0; g_fb = '0; b_fb = '0;
        buf_base = {32'h3000, 32'h2000, 32'h1000};
        repeat (3) tick();
        chk("rst_write", 64'(avm_write), 64'd0);
        chk("rst_addr",  64'(avm_address), 64'd0);
        chk("rst_bc",    64'(avm_burstcount), 64'd0);
        chk("rst_data",  avm_writedata, 64'd0);
        chk("rst_be",    64'(avm_byteenable), 64'hFF);
        chk("rst_end",   64'(end_frame), 64'd0);
        chk("rst_last",  64'(last_buf), 64'd0);
        chk("rst_cur",   64'(cur_buf), 64'd0);
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_ovf",   64'(overflow), 64'd0);
        chk("rst_ferr",  64'(frame_err), 64'd0);
        chk("rst_lvl",   64'(fifo_level), 64'd0);
        reset = 1'b0;
        tick();

        // Disarmed start is ignored.
        start_frame = 1'b1; frame_words = 24'd10;
        tick();
        start_frame = 1'b0;
        repeat (3) tick();
        chk("disarmed_busy", 64'(busy), 64'd0);
        chk("disarmed_ferr", 64'(frame_err), 64'd0);

        arm = 1'b1; tick(); arm = 1'b0; tick();
        m_cur = 0;

        run_frame(64, 0, 0, 0);
        run_frame(40, 4, 0, 0);
        wr_mode = 1;
        run_frame(1, 3, 1, 0);
        run_frame($urandom_range(2, 100), 1, 1, 0);
        run_frame($urandom_range(2, 100), 0, 1, 0);
        wr_mode = 2;
        run_frame(64, 0, 0, 0);
        wr_mode = 1;

        // Zero-length frame is ignored.
        start_frame = 1'b1; frame_words = 24'd0;
        tick();
        start_frame = 1'b0;
        repeat (3) tick();
        chk("zero_busy", 64'(busy), 64'd0);
        chk("zero_cur",  64'(cur_buf), 64'(m_cur));
        chk("zero_ferr", 64'(frame_err), 64'd0);

        run_frame(50, 0, 1, 1);
        run_frame(20, 0, 1, 0);
        run_overflow();

        arm = 1'b1; tick(); arm = 1'b0; tick();
        m_cur = 0;
        chk("arm_ovf",  64'(overflow), 64'd0);
        chk("arm_ferr", 64'(frame_err), 64'd0);
        chk("arm_cur",  64'(cur_buf), 64'd0);
        run_frame(33, 2, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
